// File: rtl/bus_serial_port_if.sv
// CPU data-bus view of the serial port: device address, write/read strobes and read-back data.
interface bus_serial_port_if;
    logic [7:0]  addr;
    logic [15:0] bus_in;
    logic        DI;
    logic        DO;
    logic [15:0] bus_out;
    logic        bus_oe;

    modport master (output addr, bus_in, DI, DO, input bus_out, bus_oe);
    modport slave  (input addr, bus_in, DI, DO, output bus_out, bus_oe);
endinterface

// File: rtl/bus_serial_port.sv
// Memory-mapped 8N1 serial console: data register at BASE, status at BASE+1,
// with small TX/RX FIFOs decoupling the CPU from bit timing.
module bus_serial_port #(
    parameter logic [7:0]  BASE         = 8'h02,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    bus_serial_port_if.slave bus,
    input  logic             rxd,
    output logic             txd
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TickW = $clog2(CLKS_PER_BIT);
    localparam logic [TickW-1:0] TickLast = TickW'(CLKS_PER_BIT - 1);
    localparam logic [TickW-1:0] TickHalf = TickW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    logic sel_data, sel_stat, rd_data, rd_stat, wr_data;
    assign sel_data = (bus.addr == BASE);
    assign sel_stat = (bus.addr == BASE + 8'd1);
    assign rd_data  = bus.DO & sel_data;
    assign rd_stat  = bus.DO & sel_stat;
    assign wr_data  = bus.DI & sel_data;

    logic unused_bus_hi;
    assign unused_bus_hi = ^bus.bus_in[15:8];

    // TX FIFO
    logic [7:0]      tx_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] tx_wr_q, tx_rd_q;
    logic [CntW-1:0] tx_cnt_q;
    logic            tx_empty, tx_full, tx_push, tx_pop, tx_idle;
    tx_state_e       tx_state_q;

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == CntW'(FIFO_DEPTH));
    assign tx_pop   = (tx_state_q == TxIdle) & ~tx_empty;
    assign tx_push  = wr_data & (~tx_full | tx_pop);
    assign tx_idle  = tx_empty & (tx_state_q == TxIdle);

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= bus.bus_in[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + PtrW'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + PtrW'(1);
            if (tx_push & ~tx_pop)      tx_cnt_q <= tx_cnt_q + CntW'(1);
            else if (~tx_push & tx_pop) tx_cnt_q <= tx_cnt_q - CntW'(1);
        end
    end

    // TX engine; txd is registered so the line holds each level for whole bit periods
    logic [7:0]       tx_shift_q;
    logic [TickW-1:0] tx_tick_q;
    logic [2:0]       tx_bit_q;
    logic             txd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TxIdle;
            tx_shift_q <= '0;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            txd_q      <= 1'b1;
        end else begin
            unique case (tx_state_q)
                TxIdle: begin
                    txd_q <= 1'b1;
                    if (!tx_empty) begin
                        tx_shift_q <= tx_mem_q[tx_rd_q];
                        tx_tick_q  <= '0;
                        tx_state_q <= TxStart;
                        txd_q      <= 1'b0;
                    end
                end
                TxStart: begin
                    if (tx_tick_q == TickLast) begin
                        tx_tick_q  <= '0;
                        tx_bit_q   <= '0;
                        txd_q      <= tx_shift_q[0];
                        tx_state_q <= TxData;
                    end else begin
                        tx_tick_q <= tx_tick_q + TickW'(1);
                    end
                end
                TxData: begin
                    if (tx_tick_q == TickLast) begin
                        tx_tick_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            txd_q      <= 1'b1;
                            tx_state_q <= TxStop;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            txd_q      <= tx_shift_q[1];
                        end
                    end else begin
                        tx_tick_q <= tx_tick_q + TickW'(1);
                    end
                end
                TxStop: begin
                    if (tx_tick_q == TickLast) tx_state_q <= TxIdle;
                    else                       tx_tick_q  <= tx_tick_q + TickW'(1);
                end
                default: tx_state_q <= TxIdle;
            endcase
        end
    end

    assign txd = txd_q;

    // RX synchronizer and engine; rx_push_q is a one-cycle strobe for a good frame
    logic             rx_meta_q, rx_sync_q, rx_push_q;
    rx_state_e        rx_state_q;
    logic [7:0]       rx_shift_q;
    logic [TickW-1:0] rx_tick_q;
    logic [2:0]       rx_bit_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_shift_q <= '0;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_push_q  <= 1'b0;
        end else begin
            rx_meta_q <= rxd;
            rx_sync_q <= rx_meta_q;
            rx_push_q <= 1'b0;
            unique case (rx_state_q)
                RxIdle: begin
                    if (!rx_sync_q) begin
                        rx_tick_q  <= '0;
                        rx_state_q <= RxStart;
                    end
                end
                RxStart: begin
                    if (rx_tick_q == TickHalf) begin
                        rx_tick_q  <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_sync_q ? RxIdle : RxData;
                    end else begin
                        rx_tick_q <= rx_tick_q + TickW'(1);
                    end
                end
                RxData: begin
                    if (rx_tick_q == TickLast) begin
                        rx_tick_q  <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_tick_q <= rx_tick_q + TickW'(1);
                    end
                end
                RxStop: begin
                    if (rx_tick_q == TickLast) begin
                        rx_push_q  <= rx_sync_q;
                        rx_state_q <= RxIdle;
                    end else begin
                        rx_tick_q <= rx_tick_q + TickW'(1);
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    // RX FIFO and sticky overrun
    logic [7:0]      rx_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] rx_wr_q, rx_rd_q;
    logic [CntW-1:0] rx_cnt_q;
    logic            rx_empty, rx_full, rx_push, rx_pop, rx_ovr_q;

    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CntW'(FIFO_DEPTH));
    assign rx_pop   = rd_data & ~rx_empty;
    assign rx_push  = rx_push_q & (~rx_full | rx_pop);

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem_q[rx_wr_q] <= rx_shift_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            rx_ovr_q <= 1'b0;
        end else begin
            if (rx_push) rx_wr_q <= rx_wr_q + PtrW'(1);
            if (rx_pop)  rx_rd_q <= rx_rd_q + PtrW'(1);
            if (rx_push & ~rx_pop)      rx_cnt_q <= rx_cnt_q + CntW'(1);
            else if (~rx_push & rx_pop) rx_cnt_q <= rx_cnt_q - CntW'(1);
            // a new overrun beats a concurrent status-read clear
            if (rx_push_q & ~rx_push) rx_ovr_q <= 1'b1;
            else if (rd_stat)         rx_ovr_q <= 1'b0;
        end
    end

    assign bus.bus_oe = bus.DO & (sel_data | sel_stat);

    always_comb begin
        bus.bus_out = '0;
        if (rd_data) begin
            bus.bus_out = {8'h00, rx_empty ? 8'h00 : rx_mem_q[rx_rd_q]};
        end else if (rd_stat) begin
            bus.bus_out = {12'h000, tx_idle, rx_ovr_q, ~tx_full, ~rx_empty};
        end
    end
endmodule

// File: tb/tb_bus_serial_port.sv
// Randomized bench for bus_serial_port against a queue-based model of the bus and serial lines.
module tb_bus_serial_port;
    localparam int         Cpb   = 4;
    localparam int         Depth = 4;
    localparam logic [7:0] Base  = 8'h02;

    logic clk = 1'b0;
    logic reset, rxd, txd;

    bus_serial_port_if bus_if ();

    bus_serial_port #(
        .BASE         (Base),
        .CLKS_PER_BIT (Cpb),
        .FIFO_DEPTH   (Depth)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .rxd   (rxd),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: byte queues plus the cycle at which the transmitter next becomes free.
    byte unsigned txq[$];
    byte unsigned rxq[$];
    byte unsigned last_byte;
    int  cyc = 0;
    int  free_at = 0;
    int  last_pop = -1000;
    bit  ovr_m = 1'b0;
    bit  model_live = 1'b0;
    int  tx_bad = 0;

    initial begin
        forever begin
            bit do_pop;
            int pre;
            @(posedge clk);
            if (reset) begin
                txq.delete();
                rxq.delete();
                free_at    = cyc + 1;
                last_pop   = -1000;
                ovr_m      = 1'b0;
                model_live = 1'b1;
            end else begin
                pre    = txq.size();
                do_pop = (cyc >= free_at) && (pre > 0);
                if (do_pop) begin
                    last_byte = txq.pop_front();
                    last_pop  = cyc;
                    free_at   = cyc + 1 + 10 * Cpb;
                end
                if (bus_if.DI && bus_if.addr == Base && (pre < Depth || do_pop))
                    txq.push_back(bus_if.bus_in[7:0]);
                if (bus_if.DO && bus_if.addr == Base && rxq.size() > 0)
                    void'(rxq.pop_front());
                if (bus_if.DO && bus_if.addr == Base + 8'd1)
                    ovr_m = 1'b0;
            end
            cyc++;
        end
    end

    // Expected line level t cycles in: start bit, 8 data bits LSB first, stop bit.
    function automatic logic exp_txd(input int t);
        int d;
        d = t - last_pop - 1;
        if (d < 0 || d >= 10 * Cpb) return 1'b1;
        d = d / Cpb;
        if (d == 0) return 1'b0;
        if (d == 9) return 1'b1;
        return last_byte[d-1];
    endfunction

    function automatic logic [15:0] stat_exp();
        logic idle_m;
        idle_m = (txq.size() == 0) && (cyc >= free_at);
        return {12'h000, idle_m, ovr_m, txq.size() < Depth, rxq.size() > 0};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (model_live && txd !== exp_txd(cyc)) tx_bad++;
        end
    end

    task automatic bus_cycle(input logic [7:0] a, input logic [15:0] d, input logic wr,
                             input logic rd);
        @(posedge clk);
        #1;
        bus_if.addr   = a;
        bus_if.bus_in = d;
        bus_if.DI     = wr;
        bus_if.DO     = rd;
    endtask

    task automatic idle(input int n);
        repeat (n) bus_cycle(8'h00, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic wr_data(input byte unsigned b);
        bus_cycle(Base, {8'($urandom), b}, 1'b1, 1'b0);
    endtask

    task automatic rd_data_chk(input string tag);
        logic [15:0] exp;
        bus_cycle(Base, 16'h0000, 1'b0, 1'b1);
        @(negedge clk);
        exp = (rxq.size() > 0) ? {8'h00, rxq[0]} : 16'h0000;
        check_eq({tag, "_data"}, bus_if.bus_out, exp);
        check_eq({tag, "_oe"}, {15'h0, bus_if.bus_oe}, 16'h0001);
    endtask

    task automatic rd_stat_chk(input string tag);
        bus_cycle(Base + 8'd1, 16'h0000, 1'b0, 1'b1);
        @(negedge clk);
        check_eq({tag, "_stat"}, bus_if.bus_out, stat_exp());
    endtask

    task automatic send_frame(input byte unsigned b, input bit good_stop);
        logic [9:0] bits;
        bits = {good_stop, b, 1'b0};
        idle(1);
        for (int k = 0; k < 10 * Cpb; k++) begin
            @(posedge clk);
            #1;
            rxd = bits[k / Cpb];
        end
        @(posedge clk);
        #1;
        rxd = 1'b1;
        if (good_stop) begin
            if (rxq.size() < Depth) rxq.push_back(b);
            else                    ovr_m = 1'b1;
        end
        idle(6);
    endtask

    initial begin
        logic [9:0] pbits;
        reset          = 1'b1;
        rxd            = 1'b1;
        bus_if.addr    = 8'h00;
        bus_if.bus_in  = 16'h0000;
        bus_if.DI      = 1'b0;
        bus_if.DO      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_txd", {15'h0, txd}, 16'h0001);
        check_eq("rst_oe", {15'h0, bus_if.bus_oe}, 16'h0000);
        check_eq("rst_out", bus_if.bus_out, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd_stat_chk("rst");

        // TX framing of one byte with a mid-frame status read
        bus_cycle(Base, 16'hAB55, 1'b1, 1'b0);
        idle(10);
        rd_stat_chk("tx_mid");
        idle(40);
        rd_stat_chk("tx_done");
        check_eq("tx_wave1", 16'(tx_bad), 16'h0000);

        // TX overflow: seven back-to-back writes
        for (int i = 0; i < 7; i++) wr_data(8'($urandom));
        idle(1);
        rd_stat_chk("tx_full");
        idle(10 * Cpb * 6 + 10);
        rd_stat_chk("tx_drain");
        check_eq("tx_wave2", 16'(tx_bad), 16'h0000);

        // RX single frame, then empty-read behaviour
        send_frame(8'h3C, 1'b1);
        rd_stat_chk("rx1");
        rd_data_chk("rx1");
        rd_stat_chk("rx1_empty");
        rd_data_chk("rx1_again");

        // RX overrun: five frames with no reads
        for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1);
        rd_stat_chk("ovr");
        for (int i = 0; i < 4; i++) rd_data_chk("ovr_rd");
        rd_stat_chk("ovr_clr");

        // Glitch and framing error
        @(posedge clk);
        #1;
        rxd = 1'b0;
        @(posedge clk);
        #1;
        rxd = 1'b1;
        idle(8);
        rd_stat_chk("glitch");
        send_frame(8'($urandom), 1'b0);
        rd_stat_chk("framing");

        // Randomized mixed traffic
        for (int r = 0; r < 4; r++) begin
            int ntx, nrx;
            ntx = $urandom_range(1, 3);
            nrx = $urandom_range(1, 2);
            for (int i = 0; i < ntx; i++) wr_data(8'($urandom));
            for (int i = 0; i < nrx; i++) send_frame(8'($urandom), 1'($urandom_range(0, 3) != 0));
            rd_stat_chk("mix");
            for (int i = 0; i < nrx; i++) rd_data_chk("mix_rd");
        end
        idle(10 * Cpb * 4 + 10);
        rd_stat_chk("mix_end");
        check_eq("tx_wave3", 16'(tx_bad), 16'h0000);

        // Reset with both engines mid-frame
        wr_data(8'($urandom));
        idle(1);
        pbits = {1'b1, 8'($urandom), 1'b0};
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            rxd = pbits[k / Cpb];
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        rxd   = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_txd", {15'h0, txd}, 16'h0001);
        rd_stat_chk("rst_mid");
        send_frame(8'hA5, 1'b1);
        rd_data_chk("post_rst");
        bus_cycle(8'h05, 16'h0000, 1'b0, 1'b1);
        @(negedge clk);
        check_eq("other_oe", {15'h0, bus_if.bus_oe}, 16'h0000);
        check_eq("other_out", bus_if.bus_out, 16'h0000);
        idle(4);
        check_eq("tx_wave4", 16'(tx_bad), 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
